reloj_ctrl: RTL and testbench
=============================

# reloj_ctrl

Run/set controller for the minutes-seconds clock counter. Divides the board clock into a one-cycle seconds `tick` and implements a two-button time-setting mode. In set mode it pauses the clock and edits the minute digits, then issues a single `load` pulse carrying the new minutes. Sits between the debounced pushbuttons and the loadable clock counter.

## Interface
- `DIV`, 50_000_000: clk cycles per second tick; legal range ≥ 2, even.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_mode`  in  1  debounced, synchronous level; rising edge advances mode.
- `btn_inc`  in  1  debounced, synchronous level; rising edge increments the selected digit.
- `cur_mu`  in  4  counter's current minute units (0..9).
- `cur_md`  in  4  counter's current minute tens (0..5).
- `tick`  out  1  one-cycle seconds enable to the counter.
- `load`  out  1  one-cycle load strobe; the counter takes `ld_mu`/`ld_md` and clears seconds.
- `ld_mu`  out  4  edited minute units.
- `ld_md`  out  4  edited minute tens.
- `mode`  out  2  0 = RUN, 1 = SET_MD, 2 = SET_MU.
- `blank_mu`, `blank_md`  out  1 each  display blanking for the digit being edited.

## Operation
- Reset value of every output: `tick=0`, `load=0`, `ld_mu=0`, `ld_md=0`, `mode=0` (RUN), `blank_*=0`. Reset also clears the prescaler, the edge-detect history and the edit registers.
- Edge detect: each button is registered once; a press is `btn & ~btn_q`. A held button produces one press.
- Prescaler: `cnt` runs 0..DIV-1 and wraps to 0. Width is $clog2(DIV).
- FSM transitions:
  - RUN + mode press → SET_MD. Capture `edit_md<=cur_md` and `edit_mu<=cur_mu`.
  - SET_MD + mode press → SET_MU.
  - SET_MU + mode press → RUN. Assert `load` for 1 cycle and clear `cnt` to 0.
- Inc press: increments `edit_md` in SET_MD, with 5 wrapping to 0. Increments `edit_mu` in SET_MU, with 9 wrapping to 0. Ignored in RUN.
- Simultaneous mode and inc press in the same cycle: mode wins; inc is discarded.
- `ld_mu`/`ld_md` always reflect the edit registers. They are only meaningful while `load=1`.
- `tick` is suppressed outside RUN, so the counter is paused while setting.
- An inc press clears `cnt` so the edited digit shows immediately. The same applies when entering a set state.
- `rst` in any state: return to RUN next cycle with no `load` pulse. The counter keeps its own value.

## Timing
- All outputs are registered.
- A press sampled in cycle N is reflected in `mode`, edit registers, `load` and `cnt` clear from cycle N+1.
- `tick=1` in the cycle after `cnt==DIV-1` while in RUN, i.e. one pulse every DIV cycles.
- After `load`, the first `tick` occurs exactly DIV cycles after the `load` cycle.
- Button to visible effect: 2 cycles (edge register plus state register).

## Configuration
- `RELOJ_CTRL_BLINK_EN` defined:
  - In SET_MD, `blank_md = (cnt >= DIV/2)`; in SET_MU, `blank_mu = (cnt >= DIV/2)`.
  - The blanking output is registered, giving a 1 Hz blink of the edited digit.
  - The other blank output stays 0.
- Not defined: `blank_mu` and `blank_md` are constant 0. The prescaler still runs in set states, with no observable effect.

## Structure
- Package `reloj_pkg` holds:
  - the mode localparams (RUN = 0, SET_MD = 1, SET_MU = 2);
  - the `MU_MAX = 9`, `MD_MAX = 5` and `SEG_MAX = 59` constants;
  - the 4-bit digit width.
- Sub-module `reloj_edge`: 1-bit rising-edge detector (clk, rst, in, press). Instantiated twice.
- FSM, prescaler and edit registers are inline in `reloj_ctrl`.

## Test plan
All scenarios use DIV=10.
- Reset, then free-run 35 cycles → `tick` pulses every 10 cycles, `mode=0`, `load` never asserted.
- Set sequence with `cur_md=2`, `cur_mu=7`: mode press, inc ×4, mode press, inc ×5, mode press.
  - Required: `load=1` for exactly 1 cycle with `ld_md=0` (2+4 wraps 5 to 0) and `ld_mu=2` (7+5 wraps 9 to 0).
  - Required: `tick` absent throughout set mode.
- After `load`: next `tick` exactly 10 cycles later; `tick` absent in SET_MD/SET_MU even when held for 50 cycles.
- `btn_mode` and `btn_inc` rise in the same cycle in RUN → `mode=1`, `edit_md` equals captured `cur_md`. Held `btn_inc` for 20 cycles → exactly one increment.
- `rst` asserted in SET_MU after edits → next cycle `mode=0`, `load=0`, `ld_mu=ld_md=0`, `tick` resumes 10 cycles after reset release.
- With `RELOJ_CTRL_BLINK_EN`: in SET_MD, `blank_md` is 0 for 5 cycles then 1 for 5 cycles, and `blank_mu=0`. An inc press restarts the phase with `blank_md=0`. Without the macro, both blank outputs stay 0.

Source files
------------

// File: rtl/reloj_pkg.sv
// rtl/reloj_pkg.sv - shared constants and types for the reloj clock controller
package reloj_pkg;

  // Digit width used for all BCD minute digits.
  localparam int DIGIT_W = 4;

  // Encodings that appear on the mode output.
  localparam logic [1:0] MODE_RUN    = 2'd0;
  localparam logic [1:0] MODE_SET_MD = 2'd1;
  localparam logic [1:0] MODE_SET_MU = 2'd2;

  // Digit limits for minute units, minute tens and seconds.
  localparam logic [DIGIT_W-1:0] MU_MAX  = 4'd9;
  localparam logic [DIGIT_W-1:0] MD_MAX  = 4'd5;
  localparam int                 SEG_MAX = 59;

  typedef enum logic [1:0] {
    S_RUN    = MODE_RUN,
    S_SET_MD = MODE_SET_MD,
    S_SET_MU = MODE_SET_MU
  } state_t;

endpackage

// File: rtl/reloj_edge.sv
// rtl/reloj_edge.sv - 1-bit rising-edge detector with registered press output
//
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset
//   in    - debounced synchronous level
//   press - one-cycle pulse, registered, the cycle after in is first seen high
module reloj_edge (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic press
);

  logic in_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q  <= 1'b0;
      press <= 1'b0;
    end else begin
      in_q  <= in;
      press <= in & ~in_q;
    end
  end

endmodule

// File: rtl/reloj_ctrl.sv
// rtl/reloj_ctrl.sv - run/set controller: seconds prescaler and two-button minute setting
//
// Optional feature macro: RELOJ_CTRL_BLINK_EN (blink the digit being edited).
//
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   btn_mode, btn_inc - debounced buttons; rising edge = press
//   cur_mu, cur_md    - counter's current minute units / tens
//   tick              - one-cycle seconds enable, only in RUN
//   load              - one-cycle strobe; counter takes ld_mu/ld_md
//   ld_mu, ld_md      - edited minute digits
//   mode              - 0 RUN, 1 SET_MD, 2 SET_MU
//   blank_mu, blank_md- display blanking of the edited digit
import reloj_pkg::*;

module reloj_ctrl #(
  parameter int DIV = 50_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_mode,
  input  logic               btn_inc,
  input  logic [DIGIT_W-1:0] cur_mu,
  input  logic [DIGIT_W-1:0] cur_md,
  output logic               tick,
  output logic               load,
  output logic [DIGIT_W-1:0] ld_mu,
  output logic [DIGIT_W-1:0] ld_md,
  output logic [1:0]         mode,
  output logic               blank_mu,
  output logic               blank_md
);

  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
`ifdef RELOJ_CTRL_BLINK_EN
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);
`endif

  logic               mode_press, inc_press;
  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [DIGIT_W-1:0] edit_mu, edit_md;

  reloj_edge u_edge_mode (.clk(clk), .rst(rst), .in(btn_mode), .press(mode_press));
  reloj_edge u_edge_inc  (.clk(clk), .rst(rst), .in(btn_inc),  .press(inc_press));

  // Next state and next prescaler value. Entering a set state, leaving to
  // RUN, or an inc press restarts the prescaler so the new digit shows at
  // once and the first tick after load lands exactly DIV cycles later.
  always_comb begin
    state_n = state;
    cnt_n   = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    case (state)
      S_RUN: begin
        if (mode_press) begin
          state_n = S_SET_MD;
          cnt_n   = '0;
        end
      end
      S_SET_MD: begin
        if (mode_press) begin
          state_n = S_SET_MU;
          cnt_n   = '0;
        end else if (inc_press) begin
          cnt_n = '0;
        end
      end
      S_SET_MU: begin
        if (mode_press) begin
          state_n = S_RUN;
          cnt_n   = '0;
        end else if (inc_press) begin
          cnt_n = '0;
        end
      end
      default: state_n = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RUN;
      cnt      <= '0;
      tick     <= 1'b0;
      load     <= 1'b0;
      edit_mu  <= '0;
      edit_md  <= '0;
      blank_mu <= 1'b0;
      blank_md <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      // Only tick when staying in RUN, so no tick coincides with a mode change.
      tick  <= (state == S_RUN) && (state_n == S_RUN) && (cnt == CNT_LAST);
      load  <= (state == S_SET_MU) && mode_press;

      // Mode press wins over a same-cycle inc press.
      case (state)
        S_RUN: begin
          if (mode_press) begin
            edit_md <= cur_md;
            edit_mu <= cur_mu;
          end
        end
        S_SET_MD: begin
          if (!mode_press && inc_press)
            edit_md <= (edit_md >= MD_MAX) ? '0 : edit_md + DIGIT_W'(1);
        end
        S_SET_MU: begin
          if (!mode_press && inc_press)
            edit_mu <= (edit_mu >= MU_MAX) ? '0 : edit_mu + DIGIT_W'(1);
        end
        default: ;
      endcase

`ifdef RELOJ_CTRL_BLINK_EN
      // Built from next-cycle values so the blink phase lines up with cnt.
      blank_md <= (state_n == S_SET_MD) && (cnt_n >= CNT_HALF);
      blank_mu <= (state_n == S_SET_MU) && (cnt_n >= CNT_HALF);
`else
      blank_md <= 1'b0;
      blank_mu <= 1'b0;
`endif
    end
  end

  assign mode  = state;
  assign ld_mu = edit_mu;
  assign ld_md = edit_md;

endmodule

// File: tb/tb_reloj_ctrl.sv
// tb/tb_reloj_ctrl.sv - self-checking bench for reloj_ctrl with DIV=10
module tb_reloj_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] cur_mu = 4'd0;
  logic [3:0] cur_md = 4'd0;
  logic       tick, load;
  logic [3:0] ld_mu, ld_md;
  logic [1:0] mode;
  logic       blank_mu, blank_md;

  int checks = 0;
  int errors = 0;
  int set_ticks = 0;

  reloj_ctrl #(.DIV(10)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_mu(cur_mu), .cur_md(cur_md), .tick(tick), .load(load),
    .ld_mu(ld_mu), .ld_md(ld_md), .mode(mode),
    .blank_mu(blank_mu), .blank_md(blank_md)
  );

  always #5 clk = ~clk;

  // Any tick seen while not in RUN is an error.
  always @(negedge clk) if (mode != 2'd0 && tick) set_ticks++;

  typedef struct {
    logic       m;
    logic       i;
    logic [1:0] exp_mode;
    logic       exp_load;
    logic [3:0] exp_md;
    logic [3:0] exp_mu;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle button pulse; returns in the cycle the press becomes visible.
  task automatic press(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    step();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    step();
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 2'd1, 1'b0, 4'd2, 4'd7};
    tbl[1]  = '{1'b0, 1'b1, 2'd1, 1'b0, 4'd3, 4'd7};
    tbl[2]  = '{1'b0, 1'b1, 2'd1, 1'b0, 4'd4, 4'd7};
    tbl[3]  = '{1'b0, 1'b1, 2'd1, 1'b0, 4'd5, 4'd7};
    tbl[4]  = '{1'b0, 1'b1, 2'd1, 1'b0, 4'd0, 4'd7};
    tbl[5]  = '{1'b1, 1'b0, 2'd2, 1'b0, 4'd0, 4'd7};
    tbl[6]  = '{1'b0, 1'b1, 2'd2, 1'b0, 4'd0, 4'd8};
    tbl[7]  = '{1'b0, 1'b1, 2'd2, 1'b0, 4'd0, 4'd9};
    tbl[8]  = '{1'b0, 1'b1, 2'd2, 1'b0, 4'd0, 4'd0};
    tbl[9]  = '{1'b0, 1'b1, 2'd2, 1'b0, 4'd0, 4'd1};
    tbl[10] = '{1'b0, 1'b1, 2'd2, 1'b0, 4'd0, 4'd2};
    tbl[11] = '{1'b1, 1'b0, 2'd0, 1'b1, 4'd0, 4'd2};

    // Reset state
    rst = 1'b1;
    step();
    step();
    check("reset tick", tick, 0);
    check("reset load", load, 0);
    check("reset mode", mode, 0);
    check("reset ld_mu", ld_mu, 0);
    check("reset ld_md", ld_md, 0);
    check("reset blank", {blank_mu, blank_md}, 0);

    // Free run: ticks at 10, 20, 30 cycles after release
    rst = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      step();
      check($sformatf("run tick k=%0d", k), tick, (k % 10 == 0) ? 1 : 0);
      check($sformatf("run load k=%0d", k), load, 0);
    end
    check("run mode", mode, 0);

    // Set sequence from 27
    cur_md = 4'd2;
    cur_mu = 4'd7;
    for (int v = 0; v < 12; v++) begin
      press(tbl[v].m, tbl[v].i);
      check($sformatf("vec%0d mode", v), mode, tbl[v].exp_mode);
      check($sformatf("vec%0d load", v), load, tbl[v].exp_load);
      check($sformatf("vec%0d ld_md", v), ld_md, tbl[v].exp_md);
      check($sformatf("vec%0d ld_mu", v), ld_mu, tbl[v].exp_mu);
    end
    // Load cycle is cycle 0; load lasts one cycle, tick comes at cycle 10
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("post-load load k=%0d", k), load, 0);
      check($sformatf("post-load tick k=%0d", k), tick, (k == 10) ? 1 : 0);
    end

    // Long stay in both set states
    press(1'b1, 1'b0);
    repeat (50) step();
    check("hold SET_MD mode", mode, 1);
    press(1'b1, 1'b0);
    repeat (50) step();
    check("hold SET_MU mode", mode, 2);
    press(1'b1, 1'b0);
    check("hold exit load", load, 1);
    check("set-mode ticks", set_ticks, 0);

    // Simultaneous mode+inc: mode wins, captured tens unchanged
    cur_md = 4'd4;
    cur_mu = 4'd3;
    step();
    press(1'b1, 1'b1);
    check("simul mode", mode, 1);
    check("simul ld_md", ld_md, 4);
    // Held inc: single increment
    btn_inc = 1'b1;
    repeat (20) step();
    btn_inc = 1'b0;
    step();
    check("held inc ld_md", ld_md, 5);

    // Reset in SET_MU after edits
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    check("pre-rst mode", mode, 2);
    check("pre-rst ld_mu", ld_mu, 5);
    rst = 1'b1;
    step();
    check("rst mode", mode, 0);
    check("rst load", load, 0);
    check("rst ld_mu", ld_mu, 0);
    check("rst ld_md", ld_md, 0);
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("post-rst tick k=%0d", k), tick, (k == 10) ? 1 : 0);
      check($sformatf("post-rst load k=%0d", k), load, 0);
    end

    // Blink phase in SET_MD, restarted by an inc press
    press(1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
`ifdef RELOJ_CTRL_BLINK_EN
      check($sformatf("blink md k=%0d", k), blank_md, (k >= 5) ? 1 : 0);
`else
      check($sformatf("blink md k=%0d", k), blank_md, 0);
`endif
      check($sformatf("blink mu k=%0d", k), blank_mu, 0);
      step();
    end
    repeat (3) step();
    press(1'b0, 1'b1);
    check("blink restart md", blank_md, 0);
    repeat (5) step();
`ifdef RELOJ_CTRL_BLINK_EN
    check("blink restart half", blank_md, 1);
`else
    check("blink restart half", blank_md, 0);
`endif
    check("blink restart mu", blank_mu, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
